alu_issue_sched: RTL and testbench
==================================

Name: alu_issue_sched

Overview:
- Two-requester issue scheduler in front of the pipelined 32-bit ALU (int add/sub, FP add/mul, shift/rotate).
- The ALU's units sample operands every cycle. Its output mux is steered by the live opcode, so opcode must equal the op whose result is emerging at capture time.
- This block arbitrates requesters, drives operands, and reserves a unique completion slot per op so no two results collide on the output mux.
- It steers alu_opcode at completion time and returns results tagged to the originating requester.

Parameters:
- LAT_INT, 3, handshake-edge-to-capture-edge latency for opcodes 000/001
- LAT_FPADD, 5, latency for opcode 010
- LAT_FPMUL, 6, latency for opcode 011
- LAT_SHIFT, 3, latency for opcodes 100-111
- MAX_LAT, 8, reservation window depth; every LAT_* must be in 1..MAX_LAT-1
- TAG_W, 4, requester tag width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester grant; combinational, may depend on req_valid
- req_op  in  6  {op1,op0}, 3b ALU opcode each
- req_a  in  64  {a1,a0}
- req_b  in  64  {b1,b0}
- req_tag  in  2*TAG_W  {tag1,tag0}
- alu_a  out  32  operand A to ALU
- alu_b  out  32  operand B to ALU
- alu_opcode  out  3  ALU output-select opcode
- alu_out  in  32  ALU result
- res_valid  out  1  result strobe, one cycle
- res_id  out  1  requester index of result
- res_tag  out  TAG_W  tag of result
- res_data  out  32  result value
- busy  out  1  any op in flight

Behaviour:
- Reservation window: MAX_LAT entries, each {used, op[2:0], id, tag}. Entry k means capture k edges from now. Every edge the window shifts down by one; entry 0 is consumed.
- Latency: L(op) from op via parameters. An op handshaken at edge E0 is captured from alu_out at edge E0+L(op).
- Eligibility: requester i is eligible iff req_valid[i] and entry L(op_i) is unused after this edge's shift.
  - Compute this as "entry L+1 currently unused". L+1 <= MAX_LAT-1 is guaranteed by the parameter rule.
- Arbitration:
  - Round-robin pointer rr, reset 0.
  - If both requesters are eligible, grant rr. If one is eligible, grant it (non-blocking).
  - At most one grant per cycle. req_ready = grant.
  - rr flips to the non-granted index only on an issue.
- Issue edge: alu_a/alu_b are registered from the winner's operands, and the window entry at L(op) is written {1,op,id,tag}.
  - With no issue, alu_a/alu_b hold their previous values. The ALU computes garbage that is never captured.
- Completion steering: alu_opcode is registered so that, during the cycle before a capture edge, it equals the op of the entry due at that edge. Otherwise it holds its last value.
- Capture: at the edge where entry 0 is used, res_data<=alu_out, res_id, res_tag, res_valid<=1. Otherwise res_valid<=0 and the other result fields hold.
- No result backpressure: requesters must accept res_valid unconditionally.
- Ordering: results may return out of order across op types. Tags disambiguate.
- busy = OR of all window used bits.
- Simultaneous issue and completion in the same cycle is allowed. The shift and the write must not clobber each other.
- Reset, asserted anytime including mid-flight:
  - All window entries cleared and in-flight ops discarded, with no res_valid for them.
  - rr=0.
  - alu_a, alu_b, res_data and res_tag are 0; alu_opcode=000; res_valid, res_id and busy are 0.
  - req_ready=0 while reset is asserted.

Decomposition:
- Shared package: opcode constants (OP_ADD=000 … OP_ROL=111), the latency parameters, and the window entry struct/width.
- One sub-module: alu_slot_window (the reservation shift register with a write port at index L and a read port at 0).
  - The arbiter, operand registers and capture stay in the top.

Test Plan:
- Single INT ADD: req0 op=000, a=5, b=7, tag=3, handshake at E0 -> res_valid at E3 with res_data=12, res_id=0, res_tag=3.
- Slot conflict: req0 FP MUL (op 011) at E0, then req1 INT ADD at E3.
  - E3 -> req_ready[1]=0 (capture E6 taken by the FP MUL). Issue occurs at E4, result at E7.
  - FP MUL result returns at E6.
- Round-robin: both requesters hold valid SHIFT-LEFT (op 110) continuously, with slots free -> grants alternate 0,1,0,1. Results return in that order, 3 edges after each issue.
- Non-blocking: req0 is blocked on a conflict while req1 has a free slot -> req1 is granted that cycle, and rr then points to 0.
- Out of order: FP ADD (op 010) at E0, then SUB (op 001, a=10, b=3) at E1.
  - SUB result 7 returns at E4, before the FP ADD at E5. alu_opcode=001 in the cycle before E4 and 010 in the cycle before E5.
- Reset mid-flight: issue FP MUL, assert reset 2 cycles later for 1 cycle -> busy=0 and no res_valid in the following 8 cycles. A new request issues normally afterwards.

Source files
------------

// File: rtl/alu_issue_sched_pkg.sv
// rtl/alu_issue_sched_pkg.sv - opcodes, latencies and reservation slot type for alu_issue_sched
package alu_issue_sched_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_FADD = 3'b010;
  localparam logic [2:0] OP_FMUL = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  localparam int LAT_INT   = 3;
  localparam int LAT_FPADD = 5;
  localparam int LAT_FPMUL = 6;
  localparam int LAT_SHIFT = 3;
  localparam int MAX_LAT   = 8;
  localparam int TAG_W     = 4;
  localparam int IDX_W     = $clog2(MAX_LAT);

  typedef struct packed {
    logic             used;
    logic [2:0]       op;
    logic             id;
    logic [TAG_W-1:0] tag;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  function automatic logic [IDX_W-1:0] lat_of(input logic [2:0] op);
    logic [IDX_W-1:0] l;
    case (op)
      OP_ADD, OP_SUB: l = IDX_W'(LAT_INT);
      OP_FADD:        l = IDX_W'(LAT_FPADD);
      OP_FMUL:        l = IDX_W'(LAT_FPMUL);
      default:        l = IDX_W'(LAT_SHIFT);
    endcase
    return l;
  endfunction

endpackage

// File: rtl/alu_slot_window.sv
// rtl/alu_slot_window.sv - completion-slot reservation shift register
// Stored index k is the slot captured k edges from now; index 0 is never stored since it is consumed on the edge.
module alu_slot_window
  import alu_issue_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  slot_t              wr_slot,
  output logic               due_valid,
  output logic               due_id,
  output logic [TAG_W-1:0]   due_tag,
  output logic               next_due_valid,
  output logic [2:0]         next_due_op,
  output logic [MAX_LAT-1:0] used
);

  slot_t [MAX_LAT-1:1] win_q;
  slot_t [MAX_LAT-1:1] win_d;

  // Shift first, then write; the eligibility check guarantees the write target is free after the shift.
  always_comb begin
    win_d = '0;
    for (int k = 1; k < MAX_LAT-1; k++) begin
      win_d[k] = win_q[k+1];
    end
    if (wr_en && (wr_idx != '0)) begin
      win_d[wr_idx] = wr_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  always_comb begin
    used = '0;
    for (int k = 1; k < MAX_LAT; k++) begin
      used[k] = win_q[k].used;
    end
  end

  assign due_valid      = win_q[1].used;
  assign due_id         = win_q[1].id;
  assign due_tag        = win_q[1].tag;
  assign next_due_valid = win_d[1].used;
  assign next_due_op    = win_d[1].op;

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - two-requester issue scheduler for the pipelined ALU
// Arbitrates, registers operands, reserves unique completion slots and steers the ALU output mux.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_op,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [31:0]        alu_out,
  output logic               res_valid,
  output logic               res_id,
  output logic [TAG_W-1:0]   res_tag,
  output logic [31:0]        res_data,
  output logic               busy
);

  logic [2:0]         op0, op1;
  logic [IDX_W-1:0]   lat0, lat1;
  logic [1:0]         elig, grant;
  logic               issue, win_id;
  logic [IDX_W-1:0]   wr_idx;
  slot_t              wr_slot;
  logic               due_valid, due_id, next_due_valid;
  logic [TAG_W-1:0]   due_tag;
  logic [2:0]         next_due_op;
  logic [MAX_LAT-1:0] used;

  logic               rr_q, rr_d;
  logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]         alu_opcode_q, alu_opcode_d;
  logic               res_valid_q, res_valid_d, res_id_q, res_id_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [31:0]        res_data_q, res_data_d;

  // Slot L after this edge's shift is slot L+1 now.
  always_comb begin
    op0     = req_op[2:0];
    op1     = req_op[5:3];
    lat0    = lat_of(op0);
    lat1    = lat_of(op1);
    elig[0] = reset & req_valid[0] & ~used[lat0 + IDX_W'(1)];
    elig[1] = reset & req_valid[1] & ~used[lat1 + IDX_W'(1)];
    if (&elig) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
    issue   = |grant;
    win_id  = grant[1];
    wr_idx  = win_id ? lat1 : lat0;
    wr_slot = '{used: 1'b1,
                op:   win_id ? op1 : op0,
                id:   win_id,
                tag:  win_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0]};
  end

  assign req_ready = grant;

  alu_slot_window u_window (
    .clk            (clk),
    .rst_n          (reset),
    .wr_en          (issue),
    .wr_idx         (wr_idx),
    .wr_slot        (wr_slot),
    .due_valid      (due_valid),
    .due_id         (due_id),
    .due_tag        (due_tag),
    .next_due_valid (next_due_valid),
    .next_due_op    (next_due_op),
    .used           (used)
  );

  always_comb begin
    rr_d         = issue ? ~win_id : rr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    if (issue) begin
      alu_a_d = win_id ? req_a[63:32] : req_a[31:0];
      alu_b_d = win_id ? req_b[63:32] : req_b[31:0];
    end
    alu_opcode_d = next_due_valid ? next_due_op : alu_opcode_q;
    res_valid_d  = due_valid;
    res_id_d     = due_valid ? due_id  : res_id_q;
    res_tag_d    = due_valid ? due_tag : res_tag_q;
    res_data_d   = due_valid ? alu_out : res_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= OP_ADD;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_tag_q    <= '0;
      res_data_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_tag_q    <= res_tag_d;
      res_data_q   <= res_data_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_tag    = res_tag_q;
  assign res_data   = res_data_q;
  assign busy       = |used;

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed self-checking bench for alu_issue_sched
`timescale 1ns/100ps
module tb_alu_issue_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_tag;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_opcode;
  logic        res_valid, res_id, busy;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src;
  logic [31:0] a_hist [64];
  logic [31:0] b_hist [64];

  alu_issue_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_id(res_id), .res_tag(res_tag), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lat(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return 3;
      3'b010:         return 5;
      3'b011:         return 6;
      default:        return 3;
    endcase
  endfunction

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a + b + 32'h100;
      3'b011:  return a * b;
      3'b100:  return a >> b[4:0];
      3'b101:  return $signed(a) >>> b[4:0];
      3'b110:  return a << b[4:0];
      default: return (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
    endcase
  endfunction

  // Pipelined ALU: output mux follows the live opcode, showing the op whose operands were registered L-1 cycles earlier.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    a_hist[cyc % 64] = alu_a;
    b_hist[cyc % 64] = alu_b;
    src = cyc - lat(alu_opcode) + 1;
    alu_out = (src > 0) ? alu_f(alu_opcode, a_hist[src % 64], b_hist[src % 64]) : 32'h0;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (i == 0) begin
      req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b; req_tag[3:0] = tag;
    end else begin
      req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b; req_tag[7:4] = tag;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_req(0, 3'b000, 1, 1, 1);
    set_req(1, 3'b000, 2, 2, 2);
    req_valid = 2'b11;
    tick();
    tick();
    checks++;
    if ({req_ready, busy, res_valid, res_id, res_tag, res_data, alu_a, alu_b, alu_opcode} !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b busy=%b rv=%b id=%b tag=%h data=%h a=%h b=%h opc=%b exp all 0",
               req_ready, busy, res_valid, res_id, res_tag, res_data, alu_a, alu_b, alu_opcode);
    end
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_add;
    set_req(0, 3'b000, 5, 7, 3);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL add_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got %b exp 1", busy); end
    for (int k = 1; k < 3; k++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early cycle %0d got %b exp 0", k, res_valid); end
    end
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b0, 4'd3, 32'd12}) begin
      errors++; $display("FAIL add_result got v=%b id=%b tag=%0d data=%0d exp v=1 id=0 tag=3 data=12", res_valid, res_id, res_tag, res_data);
    end
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_after got v=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_slot_conflict;
    set_req(0, 3'b011, 6, 7, 1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    set_req(1, 3'b000, 1, 2, 5);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL conflict_block got %b exp 00", req_ready); end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL conflict_retry got %b exp 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL conflict_e5 got %b exp 0", res_valid); end
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b0, 4'd1, 32'd42}) begin
      errors++; $display("FAIL conflict_fmul got v=%b id=%b tag=%0d data=%0d exp v=1 id=0 tag=1 data=42", res_valid, res_id, res_tag, res_data);
    end
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b1, 4'd5, 32'd3}) begin
      errors++; $display("FAIL conflict_add got v=%b id=%b tag=%0d data=%0d exp v=1 id=1 tag=5 data=3", res_valid, res_id, res_tag, res_data);
    end
    tick();
  endtask

  task automatic test_round_robin;
    logic       exp_id;
    logic [3:0] exp_tag;
    logic [31:0] exp_data;
    set_req(0, 3'b110, 1, 1, 4);
    set_req(1, 3'b110, 3, 2, 9);
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) begin
        checks++;
        if (req_ready !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant %0d got %b", k, req_ready);
        end
      end
      tick();
      if (k >= 3) begin
        exp_id   = ((k - 3) % 2 == 1);
        exp_tag  = exp_id ? 4'd9 : 4'd4;
        exp_data = exp_id ? 32'd12 : 32'd2;
        checks++;
        if ({res_valid, res_id, res_tag, res_data} !== {1'b1, exp_id, exp_tag, exp_data}) begin
          errors++; $display("FAIL rr_result %0d got v=%b id=%b tag=%0d data=%0d exp id=%b tag=%0d data=%0d",
                             k, res_valid, res_id, res_tag, res_data, exp_id, exp_tag, exp_data);
        end
      end
    end
    tick();
  endtask

  task automatic test_non_blocking;
    set_req(1, 3'b011, 3, 5, 2);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    set_req(0, 3'b000, 100, 23, 7);
    set_req(1, 3'b010, 10, 20, 6);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL nb_grant1 got %b exp 10", req_ready); end
    tick();
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL nb_rr_to_0 got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b1, 4'd2, 32'd15}) begin
      errors++; $display("FAIL nb_fmul got v=%b id=%b tag=%0d data=%0d exp v=1 id=1 tag=2 data=15", res_valid, res_id, res_tag, res_data);
    end
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b0, 4'd7, 32'd123}) begin
      errors++; $display("FAIL nb_add got v=%b id=%b tag=%0d data=%0d exp v=1 id=0 tag=7 data=123", res_valid, res_id, res_tag, res_data);
    end
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b1, 4'd6, 32'd286}) begin
      errors++; $display("FAIL nb_fadd got v=%b id=%b tag=%0d data=%0d exp v=1 id=1 tag=6 data=286", res_valid, res_id, res_tag, res_data);
    end
    tick();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL nb_idle got v=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_out_of_order;
    set_req(0, 3'b010, 1, 2, 1);
    req_valid = 2'b01;
    tick();
    set_req(0, 3'b001, 10, 3, 2);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL ooo_sub_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    checks++;
    if (alu_opcode !== 3'b001) begin errors++; $display("FAIL ooo_opc_sub got %b exp 001", alu_opcode); end
    tick();
    checks++;
    if ({res_valid, res_tag, res_data, alu_opcode} !== {1'b1, 4'd2, 32'd7, 3'b010}) begin
      errors++; $display("FAIL ooo_sub got v=%b tag=%0d data=%0d opc=%b exp v=1 tag=2 data=7 opc=010", res_valid, res_tag, res_data, alu_opcode);
    end
    tick();
    checks++;
    if ({res_valid, res_tag, res_data} !== {1'b1, 4'd1, 32'd259}) begin
      errors++; $display("FAIL ooo_fadd got v=%b tag=%0d data=%0d exp v=1 tag=1 data=259", res_valid, res_tag, res_data);
    end
    tick();
  endtask

  task automatic test_reset_midflight;
    set_req(0, 3'b011, 2, 2, 3);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++;
    if ({busy, req_ready, res_valid, alu_a} !== '0) begin
      errors++; $display("FAIL midreset_state got busy=%b ready=%b v=%b a=%h exp 0", busy, req_ready, res_valid, alu_a);
    end
    req_valid = 2'b00;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL midreset_quiet %0d got v=%b busy=%b exp 0 0", k, res_valid, busy); end
    end
    set_req(0, 3'b000, 4, 4, 9);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    checks++;
    if ({res_valid, res_id, res_tag, res_data} !== {1'b1, 1'b0, 4'd9, 32'd8}) begin
      errors++; $display("FAIL post_reset_add got v=%b id=%b tag=%0d data=%0d exp v=1 id=0 tag=9 data=8", res_valid, res_id, res_tag, res_data);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    alu_out   = '0;
    test_reset();
    test_single_add();
    test_slot_conflict();
    test_round_robin();
    test_non_blocking();
    test_out_of_order();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
